// File: rtl/hpdcache_pkg.sv
// Request/response payload types of the HPDcache core request port.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_PA_WIDTH           = 32;
    localparam int unsigned HPDCACHE_WORD_WIDTH         = 32;
    localparam int unsigned HPDCACHE_REQ_SRC_ID_WIDTH   = 3;
    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 4;

    typedef logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   hpdcache_req_sid_t;
    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef enum logic [1:0] {
        HPDCACHE_REQ_LOAD     = 2'd0,
        HPDCACHE_REQ_STORE    = 2'd1,
        HPDCACHE_REQ_PREFETCH = 2'd2,
        HPDCACHE_REQ_CMO      = 2'd3
    } hpdcache_req_op_t;

    typedef struct packed {
        logic [HPDCACHE_PA_WIDTH-1:0] addr;
        hpdcache_req_op_t             op;
        logic [2:0]                   size;
        hpdcache_req_sid_t            sid;
        hpdcache_req_tid_t            tid;
        logic                         need_rsp;
    } hpdcache_req_t;

    typedef struct packed {
        logic [HPDCACHE_WORD_WIDTH-1:0] rdata;
        hpdcache_req_sid_t              sid;
        hpdcache_req_tid_t              tid;
        logic                           error;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hwpf_stride_pkg.sv
// Shared types and elaboration helpers for the hwpf_stride prefetcher cluster.
package hwpf_stride_pkg;

    import hpdcache_pkg::*;

    localparam int unsigned       HWPF_NUM_ENGINES = 4;
    localparam hpdcache_req_sid_t HWPF_SID_DEFAULT = '0;

    // Engine index width; a single engine still needs one bit.
    function automatic int unsigned hwpf_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Every engine index must fit in the cache transaction id.
    function automatic bit hwpf_params_ok(input int unsigned n_eng, input int unsigned inflight_max);
        return (n_eng >= 1) && (n_eng <= (1 << HPDCACHE_REQ_TRANS_ID_WIDTH)) && (inflight_max >= 1);
    endfunction

    typedef logic [hwpf_id_width(HWPF_NUM_ENGINES)-1:0] hwpf_engine_id_t;

endpackage

// File: rtl/hwpf_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant from the pointer onward,
// pointer moves past the winner when en_i is high.
module hwpf_rr_arbiter
    import hwpf_stride_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = hwpf_id_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             gnt_any_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_nxt_c;

    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any_c && req_i[IDX_W'(idx)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDX_W'(idx);
            end
        end
        if (gnt_any_c) gnt_c[gnt_idx_c] = 1'b1;
        nxt = 32'(gnt_idx_c) + 1;
        if (nxt >= N) nxt = 0;
        ptr_nxt_c = IDX_W'(nxt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_nxt_c;
        end
    end

endmodule

// File: rtl/hwpf_stride_arb.sv
// Merges the hwpf_stride engines onto the HPDcache prefetch port: round-robin
// grant into a one-entry output register, tid demux of responses, inflight cap.
module hwpf_stride_arb
    import hpdcache_pkg::*;
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned       NUM_HW_PREFETCH = HWPF_NUM_ENGINES,
    parameter hpdcache_req_sid_t HWPF_SID        = HWPF_SID_DEFAULT,
    parameter int unsigned       INFLIGHT_MAX    = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
    output logic [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
    input  hpdcache_req_t              hwpf_req_i [NUM_HW_PREFETCH],
    output logic [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
    output hpdcache_rsp_t              hwpf_rsp_o,
    output logic                       hpdcache_req_valid_o,
    input  logic                       hpdcache_req_ready_i,
    output hpdcache_req_t              hpdcache_req_o,
    input  logic                       hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t              hpdcache_rsp_i,
    output logic                       busy_o
);

    localparam int unsigned ID_W  = hwpf_id_width(NUM_HW_PREFETCH);
    localparam int unsigned CNT_W = $clog2(INFLIGHT_MAX + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    if (!hwpf_params_ok(NUM_HW_PREFETCH, INFLIGHT_MAX)) begin : g_param_check
        $error("hwpf_stride_arb: NUM_HW_PREFETCH/INFLIGHT_MAX out of range");
    end

    logic                       out_valid_q;
    hpdcache_req_t              out_req_q;
    logic [CNT_W-1:0]           inflight_cnt_q;

    logic                       cache_hs_c;
    logic                       rsp_dec_c;
    logic [OCC_W-1:0]           occupancy_c;
    logic                       can_accept_c;
    logic                       grant_c;
    logic [NUM_HW_PREFETCH-1:0] arb_gnt_c;
    logic [ID_W-1:0]            arb_idx_c;
    logic                       arb_any_c;
    hpdcache_req_t              grant_req_c;

    assign cache_hs_c  = out_valid_q && hpdcache_req_ready_i;
    assign rsp_dec_c   = hpdcache_rsp_valid_i && (inflight_cnt_q != '0);

    // The buffered request counts toward the cap so its handshake can never overflow the counter.
    assign occupancy_c  = OCC_W'(inflight_cnt_q) + OCC_W'(out_valid_q);
    assign can_accept_c = rst_ni && (!out_valid_q || hpdcache_req_ready_i)
                       && ((occupancy_c < OCC_W'(INFLIGHT_MAX)) || rsp_dec_c);
    assign grant_c      = can_accept_c && arb_any_c;

    hwpf_rr_arbiter #(
        .N (NUM_HW_PREFETCH)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (hwpf_req_valid_i),
        .en_i      (grant_c),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c),
        .gnt_any_c (arb_any_c)
    );

    assign hwpf_req_ready_o = can_accept_c ? arb_gnt_c : '0;

    always_comb begin
        grant_req_c     = hwpf_req_i[arb_idx_c];
        grant_req_c.tid = HPDCACHE_REQ_TRANS_ID_WIDTH'(arb_idx_c);
        grant_req_c.sid = HWPF_SID;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
        end else if (grant_c) begin
            out_valid_q <= 1'b1;
            out_req_q   <= grant_req_c;
        end else if (hpdcache_req_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_cnt_q <= '0;
        end else if (cache_hs_c && !rsp_dec_c) begin
            inflight_cnt_q <= inflight_cnt_q + CNT_W'(1);
        end else if (!cache_hs_c && rsp_dec_c) begin
            inflight_cnt_q <= inflight_cnt_q - CNT_W'(1);
        end
    end

    for (genvar j = 0; j < NUM_HW_PREFETCH; j++) begin : g_rsp_demux
        assign hwpf_rsp_valid_o[j] = rst_ni && hpdcache_rsp_valid_i
                                  && (hpdcache_rsp_i.tid == HPDCACHE_REQ_TRANS_ID_WIDTH'(j));
    end

    assign hwpf_rsp_o           = hpdcache_rsp_i;
    assign hpdcache_req_valid_o = out_valid_q;
    assign hpdcache_req_o       = out_req_q;
    assign busy_o               = out_valid_q || (inflight_cnt_q != '0);

endmodule
